// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared constants, types and beat ordering for the nibble serializer.
// Beat order follows NIBBLE_SERIALIZER_MSB_FIRST_EN (defined: nibble 3 first; undefined: nibble 0 first).
package nibble_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int WORD_W  = NIB_W * NUM_NIB;

  typedef logic [1:0] nib_idx_t;

  typedef enum logic {IDLE, SEND} state_t;

`ifdef NIBBLE_SERIALIZER_MSB_FIRST_EN
  localparam nib_idx_t FIRST_IDX = 2'd3;
  localparam nib_idx_t LAST_IDX  = 2'd0;

  function automatic nib_idx_t next_idx(input nib_idx_t idx);
    return idx - 2'd1;
  endfunction
`else
  localparam nib_idx_t FIRST_IDX = 2'd0;
  localparam nib_idx_t LAST_IDX  = 2'd3;

  function automatic nib_idx_t next_idx(input nib_idx_t idx);
    return idx + 2'd1;
  endfunction
`endif

endpackage

// File: rtl/nibble_select.sv
// rtl/nibble_select.sv - combinational 4:1 nibble mux over a 16-bit word.
module nibble_select
  import nibble_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  nib_idx_t          idx,
  output logic [NIB_W-1:0]  nib
);

  always_comb begin
    nib = '0;
    case (idx)
      2'd0: nib = word[0*NIB_W +: NIB_W];
      2'd1: nib = word[1*NIB_W +: NIB_W];
      2'd2: nib = word[2*NIB_W +: NIB_W];
      2'd3: nib = word[3*NIB_W +: NIB_W];
      default: nib = '0;
    endcase
  end

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - emits an operand pair as four registered nibble-pair beats.
// Beat order selected by NIBBLE_SERIALIZER_MSB_FIRST_EN (default LSB-first).
module nibble_serializer
  import nibble_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] src_data1,
  input  logic [WORD_W-1:0] src_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIB_W-1:0]  out_nib1,
  output logic [NIB_W-1:0]  out_nib2,
  output nib_idx_t          out_idx,
  output logic              out_last,
  output logic              busy
);

  state_t            state;
  logic [WORD_W-1:0] op1;
  logic [WORD_W-1:0] op2;

  logic              accept;
  logic              beat_done;
  nib_idx_t          nxt_idx;
  nib_idx_t          sel_idx;
  logic [WORD_W-1:0] sel_word1;
  logic [WORD_W-1:0] sel_word2;
  logic [NIB_W-1:0]  sel_nib1;
  logic [NIB_W-1:0]  sel_nib2;

  assign beat_done = out_valid && out_ready;
  assign in_ready  = (state == IDLE) || (beat_done && out_last);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == SEND);
  assign nxt_idx   = next_idx(out_idx);

  // A fresh pair is muxed straight from the inputs so beat 0 is ready one cycle after acceptance.
  assign sel_word1 = accept ? src_data1 : op1;
  assign sel_word2 = accept ? src_data2 : op2;
  assign sel_idx   = accept ? FIRST_IDX : nxt_idx;

  nibble_select u_sel1 (
    .word (sel_word1),
    .idx  (sel_idx),
    .nib  (sel_nib1)
  );

  nibble_select u_sel2 (
    .word (sel_word2),
    .idx  (sel_idx),
    .nib  (sel_nib2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op1       <= '0;
      op2       <= '0;
      out_valid <= 1'b0;
      out_nib1  <= '0;
      out_nib2  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      state     <= SEND;
      op1       <= src_data1;
      op2       <= src_data2;
      out_valid <= 1'b1;
      out_nib1  <= sel_nib1;
      out_nib2  <= sel_nib2;
      out_idx   <= FIRST_IDX;
      out_last  <= (FIRST_IDX == LAST_IDX);
    end else if (beat_done) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_nib1  <= sel_nib1;
        out_nib2  <= sel_nib2;
        out_idx   <= nxt_idx;
        out_last  <= (nxt_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - scoreboard bench for nibble_serializer (honours NIBBLE_SERIALIZER_MSB_FIRST_EN).
module tb_nibble_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] src_data1 = '0;
  logic [15:0] src_data2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_nib1;
  logic [3:0]  out_nib2;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int accepts = 0;
  logic [10:0] sb[$];

  nibble_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_data1 (src_data1),
    .src_data2 (src_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_nib1  (out_nib1),
    .out_nib2  (out_nib2),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat k of a transaction: {nib1, nib2, idx, last}.
  function automatic logic [10:0] beat(input logic [15:0] d1, input logic [15:0] d2, input int k);
    logic [1:0] idx;
`ifdef NIBBLE_SERIALIZER_MSB_FIRST_EN
    idx = 2'(3 - k);
`else
    idx = 2'(k);
`endif
    return {d1[idx*4 +: 4], d2[idx*4 +: 4], idx, (k == 3)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) check("unexpected_beat", 1, 0);
        else check("beat", {out_nib1, out_nib2, out_idx, out_last}, sb.pop_front());
      end
      if (in_valid && in_ready) begin
        accepts++;
        for (int k = 0; k < 4; k++) sb.push_back(beat(src_data1, src_data2, k));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] d1, input logic [15:0] d2);
    in_valid  = 1'b1;
    src_data1 = d1;
    src_data2 = d2;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Second pair is offered from beat 0 of the first and must be taken only on the last-beat handshake.
  task automatic b2b(input logic [15:0] a1, input logic [15:0] a2,
                     input logic [15:0] b1, input logic [15:0] b2);
    int p0, a0;
    logic [10:0] e;
    out_ready = 1'b1;
    a0 = accepts;
    start(a1, a2);
    p0 = pops;
    in_valid  = 1'b1;
    src_data1 = b1;
    src_data2 = b2;
    for (int k = 0; k < 3; k++) begin
      check("busy_in_ready", in_ready, 0);
      tick();
    end
    check("last_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    e = beat(b1, b2, 0);
    check("b2b_first", {out_valid, busy, out_nib1, out_nib2, out_idx}, {2'b11, e[10:1]});
    repeat (4) tick();
    check("b2b_beats_in_8", pops - p0, 8);
    check("b2b_accepts", accepts - a0, 2);
    check_idle("b2b_idle");
  endtask

  initial begin
    logic [10:0] e;

    repeat (2) tick();
    check("reset_outputs", {out_valid, out_nib1, out_nib2, out_idx, out_last, busy}, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Single transaction at full rate.
    out_ready = 1'b1;
    start(16'h4321, 16'h8765);
    e = beat(16'h4321, 16'h8765, 0);
    check("first_latency", {out_valid, out_nib1, out_nib2, out_idx, out_last}, {1'b1, e});
    repeat (4) tick();
    check_idle("single_idle");

    // Stall on the second beat for three cycles.
    start(16'h4321, 16'h8765);
    tick();
    out_ready = 1'b0;
    e = beat(16'h4321, 16'h8765, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_hold", {out_valid, out_nib1, out_nib2, out_idx, out_last}, {1'b1, e});
    end
    out_ready = 1'b1;
    repeat (3) tick();
    check_idle("stall_idle");

    b2b(16'h4321, 16'h8765, 16'hFFFF, 16'h0000);
    b2b(16'h4321, 16'h8765, 16'hAAAA, 16'h5555);

    // Asynchronous abort on the third beat.
    start(16'h4321, 16'h8765);
    repeat (2) tick();
    e = beat(16'h4321, 16'h8765, 2);
    check("pre_abort_idx", out_idx, e[2:1]);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_immediate", {out_valid, busy, out_idx}, 0);
    #3;
    rst = 1'b0;
    tick();
    start(16'h0001, 16'h0002);
    e = beat(16'h0001, 16'h0002, 0);
    check("post_abort_first", {out_valid, out_nib1, out_nib2, out_idx, out_last}, {1'b1, e});
    repeat (4) tick();
    check_idle("post_abort_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
